// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the sequencer state encoding and the requester ids.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_AUX = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
// On a tie the port that did not win last time is chosen.
module rr_arbiter2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);

   always_comb begin
      grant_valid = |req;
      grant_id    = REQ_CPU;
      if (req == 2'b11) begin
         grant_id = ~last_grant;
      end else if (req[1]) begin
         grant_id = REQ_AUX;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port sequencer in front of the single-port data memory: one access
// every three cycles (IDLE -> ACCESS -> RESP), with alignment/range rejection.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_BYTES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_done,
   output logic              p0_err,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_done,
   output logic              p1_err,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              MemWrite,
   output logic              MemRead,
   output logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] writeData,
   input  logic [DATA_W-1:0] readData,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

   arb_state_e        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              id_q, id_d;
   logic              we_q, we_d;
   logic              bad_q, bad_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
   logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

   logic              grant_valid;
   logic              grant_id;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic [DATA_W-1:0] rd_val;

   rr_arbiter2 u_rr (
      .req         ({p1_req, p0_req}),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign win_we    = (grant_id == REQ_AUX) ? p1_we    : p0_we;
   assign win_addr  = (grant_id == REQ_AUX) ? p1_addr  : p0_addr;
   assign win_wdata = (grant_id == REQ_AUX) ? p1_wdata : p0_wdata;
   assign rd_val    = (!we_q && !bad_q) ? readData : '0;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      we_d         = we_q;
      bad_d        = bad_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      p0_rdata_d   = p0_rdata_q;
      p1_rdata_d   = p1_rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               id_d    = grant_id;
               we_d    = win_we;
               addr_d  = win_addr;
               wdata_d = win_wdata;
               bad_d   = (win_addr[1:0] != 2'b00) || (win_addr >= MEM_LIMIT);
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // Rejected accesses and writes return zero rather than stale data.
            if (id_q == REQ_AUX) begin
               p1_rdata_d = rd_val;
            end else begin
               p0_rdata_d = rd_val;
            end
            last_grant_d = id_q;
            state_d      = RESP;
         end
         RESP: begin
            p0_rdata_d = '0;
            p1_rdata_d = '0;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= REQ_AUX;
         id_q         <= REQ_CPU;
         we_q         <= 1'b0;
         bad_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         p0_rdata_q   <= '0;
         p1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         we_q         <= we_d;
         bad_q        <= bad_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         p0_rdata_q   <= p0_rdata_d;
         p1_rdata_q   <= p1_rdata_d;
      end
   end

   // Strobes derive only from the async-reset state, so reset kills them at once.
   assign MemWrite  = (state_q == ACCESS) && !bad_q && we_q;
   assign MemRead   = (state_q == ACCESS) && !bad_q && !we_q;
   assign Address   = addr_q;
   assign writeData = wdata_q;
   assign busy      = (state_q != IDLE);

   assign p0_gnt   = (state_q == ACCESS) && (id_q == REQ_CPU);
   assign p1_gnt   = (state_q == ACCESS) && (id_q == REQ_AUX);
   assign p0_done  = (state_q == RESP) && (id_q == REQ_CPU);
   assign p1_done  = (state_q == RESP) && (id_q == REQ_AUX);
   assign p0_err   = p0_done && bad_q;
   assign p1_err   = p1_done && bad_q;
   assign p0_rdata = p0_rdata_q;
   assign p1_rdata = p1_rdata_q;

endmodule
